spike_event_scheduler: RTL and testbench
========================================

# spike_event_scheduler

Shares one weighted synaptic accumulator between the input-neuron spike lines of the LIF network and drives the output neuron's 5-bit input current. Spikes are latched as pending events. A round-robin arbiter grants one event per cycle, and the granted event's weight is added into a saturating, periodically decaying accumulator. Per-input weights are runtime-configurable through a valid/ready write port.

## Interface
- `N_IN`, 3: number of input spike lines (2..8).
- `W`, 5: width of weights, accumulator and `current_out`.
- `W_INIT`, 2: reset value of every weight.
- `DECAY_PERIOD`, 16: cycles between decay steps; 0 disables decay.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `spike_in`  in  N_IN  one-cycle spike pulses from the input neurons.
- `cfg_valid`  in  1  weight-write request.
- `cfg_sel`  in  3  target input index.
- `cfg_weight`  in  W  new weight value.
- `cfg_ready`  out  1  write accepted when high together with `cfg_valid`.
- `cfg_err`  out  1  one-cycle pulse: accepted write had `cfg_sel >= N_IN`.
- `grant`  out  N_IN  registered one-hot event serviced this cycle; 0 when idle.
- `current_out`  out  W  accumulator value; connects to the output neuron's current input.
- `drop_count`  out  8  saturating count of lost spikes.

## Operation
- State machine: IDLE, ARB, CFG. Reset state is IDLE.
  - IDLE → CFG when `cfg_valid` is high.
  - IDLE → ARB when any pending bit is set and `cfg_valid` is low.
  - ARB → IDLE when the pending vector becomes 0 after the current grant.
  - CFG → IDLE unconditionally after one cycle.
- `cfg_ready` = (state == IDLE). A write has priority over arbitration only when it is in IDLE.
- Config handshake:
  - The handshake latches `cfg_sel` and `cfg_weight`.
  - The weight register is written during CFG and is used from the next grant onward.
  - If `cfg_sel >= N_IN`, no register is written and `cfg_err` pulses during CFG.
- Pending bits:
  - A sampled `spike_in[i]` sets `pending[i]`.
  - `spike_in[i]` while `pending[i]` is set and not being granted this cycle: the spike is dropped and `drop_count` increments, saturating at 255.
  - A spike in the same cycle as the grant of that index leaves `pending[i]` set as a new event; this is not a drop.
  - Multiple drops in one cycle add their count, with saturation.
- Arbitration, in ARB only:
  - Round-robin search starts at index `last+1` modulo N_IN.
  - The first pending index is granted and its pending bit is cleared.
  - `last` updates to the granted index. `last` resets to N_IN-1, so index 0 wins first.
- Spikes arriving in CFG or IDLE are latched, never lost, subject to the overflow rule above.
- Accumulator, applied every cycle:
  - acc_next = min(2^W-1, dec(acc) + (grant ? weight[granted] : 0)).
  - The sum is computed in W+1 bits.
- Decay:
  - A counter runs 0..DECAY_PERIOD-1 in every state.
  - On terminal count, dec(acc) = acc >> 1; otherwise dec(acc) = acc.
  - Decay and add in the same cycle: the shift is applied first, then the add.
- `current_out` = acc.
- Reset values, all asserted asynchronously:
  - `cfg_ready` = 1 (IDLE), `cfg_err` = 0, `grant` = 0, `current_out` = 0, `drop_count` = 0.
  - pending = 0, weights = `W_INIT`, decay counter = 0.
- Reset mid-operation discards pending events and the latched config, and returns to IDLE.

## Timing
- Spike sampled at edge k sets pending after edge k.
- Earliest grant is registered at edge k+1; `current_out` changes after edge k+1. Latency is 2 edges from the spike-high cycle.
- Throughput is one event per cycle in ARB. N simultaneous spikes drain in N consecutive cycles.
- A config write costs one CFG cycle plus the accept cycle. An arbitration burst in progress is never interrupted.
- `grant` and `current_out` for the same event are valid in the same cycle.

## Structure
- Shared package `snn_pkg` holds:
  - `W` and `W_INIT` defaults.
  - The state encoding (IDLE/ARB/CFG).
  - The saturating-add function.
- Sub-module `rr_arbiter` (pending vector, `last` index → one-hot grant, combinational) is natural. Everything else lives in the top.

## Test plan
- Reset with `spike_in` = 3'b111 held: all outputs at reset values. First edge after release sets pending. Grants follow 001, 010, 100 on consecutive cycles. `current_out` steps 2, 4, 6.
- Repeated all-three spikes with `DECAY_PERIOD` = 0: `current_out` saturates at 31 and stays there. `drop_count` stays 0 while each pulse is spaced ≥3 cycles apart.
- `spike_in[0]` high every cycle for 4 cycles: 4 grants of index 0 (pending re-set at each grant), no drops. The same pulse with a higher index pending creates drops that are counted.
- Write `cfg_sel` = 1, weight 7 while IDLE: `cfg_ready` drops for one cycle. The next spike on line 1 adds 7. Write `cfg_sel` = 5: `cfg_err` pulses and weights are unchanged.
- `DECAY_PERIOD` = 4 with acc = 20: the value becomes 10 at the next terminal count. A grant of weight 2 in that same cycle gives 12.
- Assert reset mid-burst with 2 events pending: `grant` = 0 immediately, `current_out` = 0. After release, no stale grants appear.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks:
// default widths, scheduler state encoding and a saturating adder.
package snn_pkg;

    localparam int SNN_W      = 5;
    localparam int SNN_W_INIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_CFG  = 2'd2
    } sched_state_e;

    // Unsigned add clamped to 2^w-1; operands must already fit in w bits (w <= 15).
    function automatic logic [15:0] sat_add(input logic [15:0] a,
                                            input logic [15:0] b,
                                            input int          w);
        logic [16:0] sum;
        logic [16:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (17'(1) << w) - 17'(1);
        return (sum > max_val) ? max_val[15:0] : sum[15:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches the pending vector starting
// one past the last serviced index and returns a one-hot grant plus its index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(last) + k;
            if (idx >= N) idx = idx - N;
            if (!grant_any && pending[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
                grant_any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_event_scheduler.sv
// Latches input spikes as pending events, services one per cycle round-robin,
// and folds the granted weight into a saturating, periodically halved current.
module spike_event_scheduler
    import snn_pkg::*;
#(
    parameter int N_IN         = 3,
    parameter int W            = SNN_W,
    parameter int W_INIT       = SNN_W_INIT,
    parameter int DECAY_PERIOD = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] spike_in,
    input  logic            cfg_valid,
    input  logic [2:0]      cfg_sel,
    input  logic [W-1:0]    cfg_weight,
    output logic            cfg_ready,
    output logic            cfg_err,
    output logic [N_IN-1:0] grant,
    output logic [W-1:0]    current_out,
    output logic [7:0]      drop_count
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;

    sched_state_e     state, state_next;
    logic [N_IN-1:0]  pending, pending_next;
    logic [IDX_W-1:0] last;
    logic [W-1:0]     weight [N_IN];
    logic [2:0]       cfg_sel_q;
    logic [W-1:0]     cfg_weight_q;
    logic [CNT_W-1:0] decay_cnt;

    logic [N_IN-1:0]  arb_onehot, arb_clear, drop_vec;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any, arb_en, handshake, decay_tick;
    logic             cfg_sel_ok, cfg_in_range;
    logic [3:0]       drop_n;
    logic [W-1:0]     acc_dec, add_w;

    logic [W-1:0]     acc_p1;
    logic [N_IN-1:0]  grant_p1;

    rr_arbiter #(
        .N     (N_IN),
        .IDX_W (IDX_W)
    ) u_arb (
        .pending   (pending),
        .last      (last),
        .grant     (arb_onehot),
        .grant_idx (arb_idx),
        .grant_any (arb_any)
    );

    // p0: event selection, pending update, overflow detection
    assign arb_en       = (state == ST_ARB);
    assign arb_clear    = (arb_en && arb_any) ? arb_onehot : '0;
    assign handshake    = cfg_valid && (state == ST_IDLE);
    assign pending_next = (pending & ~arb_clear) | spike_in;
    assign drop_vec     = spike_in & pending & ~arb_clear;
    assign cfg_sel_ok   = ({1'b0, cfg_sel_q} < 4'(N_IN));
    assign cfg_in_range = ({1'b0, cfg_sel} < 4'(N_IN));
    assign decay_tick   = (DECAY_PERIOD != 0) && (decay_cnt == CNT_W'(DECAY_PERIOD - 1));

    always_comb begin
        drop_n = '0;
        for (int i = 0; i < N_IN; i++) begin
            drop_n = drop_n + 4'(drop_vec[i]);
        end
    end

    always_comb begin
        acc_dec = decay_tick ? (acc_p1 >> 1) : acc_p1;
        add_w   = (arb_en && arb_any) ? weight[arb_idx] : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cfg_valid)          state_next = ST_CFG;
                else if (|pending_next) state_next = ST_ARB;
            end
            ST_ARB:  if (pending_next == '0) state_next = ST_IDLE;
            ST_CFG:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // p1: registered grant, accumulator and bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            pending      <= '0;
            last         <= IDX_W'(N_IN - 1);
            cfg_sel_q    <= '0;
            cfg_weight_q <= '0;
            cfg_err      <= 1'b0;
            grant_p1     <= '0;
            acc_p1       <= '0;
            drop_count   <= '0;
            decay_cnt    <= '0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            grant_p1 <= arb_clear;
            if (arb_en && arb_any) last <= arb_idx;
            if (handshake) begin
                cfg_sel_q    <= cfg_sel;
                cfg_weight_q <= cfg_weight;
            end
            cfg_err    <= handshake && !cfg_in_range;
            acc_p1     <= W'(sat_add(16'(acc_dec), 16'(add_w), W));
            drop_count <= 8'(sat_add(16'(drop_count), 16'(drop_n), 8));
            if (DECAY_PERIOD == 0 || decay_tick) decay_cnt <= '0;
            else                                 decay_cnt <= decay_cnt + 1'b1;
        end
    end

    // A write lands at the end of the CFG cycle, so the following grant already sees it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) weight[i] <= W'(W_INIT);
        end else if (state == ST_CFG && cfg_sel_ok) begin
            weight[cfg_sel_q[IDX_W-1:0]] <= cfg_weight_q;
        end
    end

    assign cfg_ready   = (state == ST_IDLE);
    assign grant       = grant_p1;
    assign current_out = acc_p1;

endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler: one instance without decay for
// arbitration/config/overflow scenarios, one with a 4-cycle decay period.
module tb_spike_event_scheduler;

    logic       clk;
    logic       reset;
    logic [2:0] spike_in;
    logic       cfg_valid;
    logic [2:0] cfg_sel;
    logic [4:0] cfg_weight;

    logic       cfg_ready, cfg_err;
    logic [2:0] grant;
    logic [4:0] current_out;
    logic [7:0] drop_count;

    logic       d_cfg_ready, d_cfg_err;
    logic [2:0] d_grant;
    logic [4:0] d_current_out;
    logic [7:0] d_drop_count;

    int n_cmp = 0;
    int n_fail = 0;

    spike_event_scheduler #(
        .N_IN(3), .W(5), .W_INIT(2), .DECAY_PERIOD(0)
    ) dut (
        .clk(clk), .reset(reset), .spike_in(spike_in),
        .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_weight(cfg_weight),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .grant(grant),
        .current_out(current_out), .drop_count(drop_count)
    );

    spike_event_scheduler #(
        .N_IN(3), .W(5), .W_INIT(2), .DECAY_PERIOD(4)
    ) dut_d (
        .clk(clk), .reset(reset), .spike_in(spike_in),
        .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_weight(cfg_weight),
        .cfg_ready(d_cfg_ready), .cfg_err(d_cfg_err), .grant(d_grant),
        .current_out(d_current_out), .drop_count(d_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; spike_in = '0; cfg_valid = 1'b0; cfg_sel = '0; cfg_weight = '0;
        step(); step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] exp_g [3] = '{3'b001, 3'b010, 3'b100};
        logic [4:0] exp_c [3] = '{5'd2, 5'd4, 5'd6};
        reset = 1'b0; spike_in = 3'b111; cfg_valid = 1'b0; cfg_sel = '0; cfg_weight = '0;
        step(); step();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cfg_ready got %b want 1", cfg_ready); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_err got %b want 0", cfg_err); end
        n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rst_grant got %b want 000", grant); end
        n_cmp++; if (current_out !== 5'd0) begin n_fail++; $display("FAIL rst_current got %0d want 0", current_out); end
        n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_drop got %0d want 0", drop_count); end
        reset = 1'b1;
        step();
        spike_in = '0;
        n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rst_first_edge_grant got %b want 000", grant); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL rst_burst_grant[%0d] got %b want %b", k, grant, exp_g[k]); end
            n_cmp++; if (current_out !== exp_c[k]) begin n_fail++; $display("FAIL rst_burst_current[%0d] got %0d want %0d", k, current_out, exp_c[k]); end
        end
        step();
        n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL rst_burst_end_grant got %b want 000", grant); end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int p = 0; p < 6; p++) begin
            spike_in = 3'b111;
            step();
            spike_in = '0;
            step(); step(); step();
            if (p == 0) begin
                n_cmp++; if (current_out !== 5'd6) begin n_fail++; $display("FAIL sat_first_pulse got %0d want 6", current_out); end
            end
            if (p == 4) begin
                n_cmp++; if (current_out !== 5'd30) begin n_fail++; $display("FAIL sat_below_max got %0d want 30", current_out); end
            end
        end
        n_cmp++; if (current_out !== 5'd31) begin n_fail++; $display("FAIL sat_max got %0d want 31", current_out); end
        n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL sat_no_drops got %0d want 0", drop_count); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_c [4] = '{5'd2, 5'd4, 5'd6, 5'd8};
        apply_reset();
        spike_in = 3'b001;
        step();
        for (int k = 0; k < 4; k++) begin
            spike_in = (k < 3) ? 3'b001 : 3'b000;
            step();
            n_cmp++; if (grant !== 3'b001) begin n_fail++; $display("FAIL b2b_grant[%0d] got %b want 001", k, grant); end
            n_cmp++; if (current_out !== exp_c[k]) begin n_fail++; $display("FAIL b2b_current[%0d] got %0d want %0d", k, current_out, exp_c[k]); end
        end
        step();
        n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL b2b_idle_grant got %b want 000", grant); end
        n_cmp++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL b2b_drops got %0d want 0", drop_count); end
    endtask

    task automatic test_drops();
        logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
        apply_reset();
        spike_in = 3'b111;
        step();
        for (int k = 0; k < 4; k++) begin
            spike_in = (k == 0) ? 3'b111 : 3'b000;
            step();
            n_cmp++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL drop_grant[%0d] got %b want %b", k, grant, exp_g[k]); end
            n_cmp++; if (drop_count !== 8'd2) begin n_fail++; $display("FAIL drop_count[%0d] got %0d want 2", k, drop_count); end
        end
        step();
        n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL drop_idle_grant got %b want 000", grant); end
        spike_in = 3'b111;
        for (int k = 0; k < 140; k++) step();
        spike_in = '0;
        n_cmp++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL drop_saturate got %0d want 255", drop_count); end
        for (int k = 0; k < 4; k++) step();
    endtask

    task automatic test_cfg();
        logic [2:0] exp_g [3] = '{3'b100, 3'b001, 3'b010};
        logic [4:0] exp_c [3] = '{5'd9, 5'd11, 5'd18};
        apply_reset();
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_weight = 5'd7;
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_idle got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_ready_busy got %b want 0", cfg_ready); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_valid_sel got %b want 0", cfg_err); end
        step();
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_ready_back got %b want 1", cfg_ready); end
        spike_in = 3'b010;
        step();
        spike_in = '0;
        step();
        n_cmp++; if (grant !== 3'b010) begin n_fail++; $display("FAIL cfg_line1_grant got %b want 010", grant); end
        n_cmp++; if (current_out !== 5'd7) begin n_fail++; $display("FAIL cfg_line1_weight got %0d want 7", current_out); end
        cfg_valid = 1'b1; cfg_sel = 3'd5; cfg_weight = 5'd9;
        step();
        cfg_valid = 1'b0;
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL cfg_err_pulse got %b want 1", cfg_err); end
        step();
        n_cmp++; if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_clear got %b want 0", cfg_err); end
        spike_in = 3'b111;
        step();
        spike_in = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (grant !== exp_g[k]) begin n_fail++; $display("FAIL cfg_rr_grant[%0d] got %b want %b", k, grant, exp_g[k]); end
            n_cmp++; if (current_out !== exp_c[k]) begin n_fail++; $display("FAIL cfg_keep_weights[%0d] got %0d want %0d", k, current_out, exp_c[k]); end
        end
    endtask

    task automatic test_decay();
        apply_reset();
        cfg_valid = 1'b1; cfg_sel = 3'd0; cfg_weight = 5'd20;
        step();
        cfg_valid = 1'b0;
        step();
        cfg_valid = 1'b1; cfg_sel = 3'd1; cfg_weight = 5'd10; spike_in = 3'b001;
        step();
        cfg_valid = 1'b0; spike_in = '0;
        step(); step(); step();
        n_cmp++; if (d_grant !== 3'b001) begin n_fail++; $display("FAIL dec_grant0 got %b want 001", d_grant); end
        n_cmp++; if (d_current_out !== 5'd20) begin n_fail++; $display("FAIL dec_load20 got %0d want 20", d_current_out); end
        step();
        n_cmp++; if (d_current_out !== 5'd20) begin n_fail++; $display("FAIL dec_hold20 got %0d want 20", d_current_out); end
        step();
        n_cmp++; if (d_current_out !== 5'd10) begin n_fail++; $display("FAIL dec_halve got %0d want 10", d_current_out); end
        spike_in = 3'b010;
        step();
        spike_in = '0;
        step();
        n_cmp++; if (d_current_out !== 5'd20) begin n_fail++; $display("FAIL dec_reload20 got %0d want 20", d_current_out); end
        spike_in = 3'b100;
        step();
        spike_in = '0;
        n_cmp++; if (d_current_out !== 5'd20) begin n_fail++; $display("FAIL dec_pre_tick got %0d want 20", d_current_out); end
        step();
        n_cmp++; if (d_grant !== 3'b100) begin n_fail++; $display("FAIL dec_grant2 got %b want 100", d_grant); end
        n_cmp++; if (d_current_out !== 5'd12) begin n_fail++; $display("FAIL dec_shift_then_add got %0d want 12", d_current_out); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        spike_in = 3'b111;
        step();
        spike_in = '0;
        step();
        n_cmp++; if (grant !== 3'b001) begin n_fail++; $display("FAIL mid_pre_grant got %b want 001", grant); end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL mid_async_grant got %b want 000", grant); end
        n_cmp++; if (current_out !== 5'd0) begin n_fail++; $display("FAIL mid_async_current got %0d want 0", current_out); end
        n_cmp++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL mid_async_ready got %b want 1", cfg_ready); end
        step();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++; if (grant !== 3'b000) begin n_fail++; $display("FAIL mid_stale_grant[%0d] got %b want 000", k, grant); end
            n_cmp++; if (current_out !== 5'd0) begin n_fail++; $display("FAIL mid_stale_current[%0d] got %0d want 0", k, current_out); end
        end
    endtask

    initial begin
        reset = 1'b0; spike_in = '0; cfg_valid = 1'b0; cfg_sel = '0; cfg_weight = '0;
        test_reset();
        test_saturate();
        test_back_to_back();
        test_drops();
        test_cfg();
        test_decay();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
